bsg_link_downstream_ctrl: RTL and testbench



---
 rtl/bsg_link_downstream_ctrl.sv | 110 +++++++++++
 tb/tb_bsg_link_downstream_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bsg_link_downstream_ctrl.sv
// Downstream DDR link controller: link bring-up sequencing, core dequeue gating,
// buffer occupancy tracking and decimated token return to the upstream sender.
module bsg_link_downstream_ctrl #(
  parameter int FIFO_DEPTH       = 64,
  parameter int TOKEN_DECIMATION = 4,
  parameter int RESET_CYCLES     = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              relink_i,
  input  logic                              io_valid_i,
  input  logic                              core_valid_i,
  input  logic                              core_ready_i,
  output logic                              core_valid_o,
  output logic                              core_yumi_o,
  output logic                              link_reset_o,
  output logic                              token_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   occupancy_o,
  output logic                              link_up_o,
  output logic                              overflow_o
);

  localparam int OCC_W  = $clog2(FIFO_DEPTH+1);
  localparam int CNT_W  = $clog2(RESET_CYCLES+1);
  localparam int PEND_W = $clog2(TOKEN_DECIMATION+1);

  typedef enum logic [1:0] {S_RESET, S_DRAIN, S_ACTIVE, S_ERROR} state_e;

  state_e              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [OCC_W-1:0]    r_occ;
  logic [PEND_W-1:0]   r_pend;
  logic                r_token;
  logic                r_ovf;

  logic                w_yumi;
  logic                w_full;
  logic                w_ovf;
  logic [PEND_W-1:0]   w_pend_inc;

  assign w_yumi     = core_valid_i & core_ready_i;
  assign w_full     = (r_occ == OCC_W'(FIFO_DEPTH));
  assign w_ovf      = io_valid_i & ~w_yumi & w_full;
  assign w_pend_inc = r_pend + PEND_W'(1);

  // Drain discards stale flits regardless of consumer readiness.
  always_comb begin
    core_valid_o = 1'b0;
    core_yumi_o  = 1'b0;
    if (!rst) begin
      case (r_state)
        S_DRAIN:  core_yumi_o = core_valid_i;
        S_ACTIVE: begin
          core_valid_o = core_valid_i;
          core_yumi_o  = w_yumi;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || relink_i) begin
      r_state <= S_RESET;
      r_cnt   <= '0;
      r_occ   <= '0;
      r_pend  <= '0;
      r_token <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_token <= 1'b0;
      case (r_state)
        S_RESET: begin
          if (r_cnt == CNT_W'(RESET_CYCLES-1)) r_state <= S_DRAIN;
          else                                 r_cnt   <= r_cnt + CNT_W'(1);
        end
        S_DRAIN: begin
          if (!core_valid_i) r_state <= S_ACTIVE;
        end
        S_ACTIVE: begin
          // Occupancy freezes on overflow; a yumi at empty does not wrap.
          if (w_ovf) begin
            r_state <= S_ERROR;
            r_ovf   <= 1'b1;
          end else if (io_valid_i && !w_yumi) begin
            r_occ <= r_occ + OCC_W'(1);
          end else if (w_yumi && !io_valid_i && r_occ != '0) begin
            r_occ <= r_occ - OCC_W'(1);
          end
          if (w_yumi) begin
            if (w_pend_inc == PEND_W'(TOKEN_DECIMATION)) begin
              r_pend  <= '0;
              r_token <= 1'b1;
            end else begin
              r_pend  <= w_pend_inc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign link_reset_o = rst | (r_state == S_RESET);
  assign link_up_o    = (r_state == S_ACTIVE);
  assign token_o      = r_token;
  assign occupancy_o  = r_occ;
  assign overflow_o   = r_ovf;

endmodule

// File: tb/tb_bsg_link_downstream_ctrl.sv
// Bench for bsg_link_downstream_ctrl: directed bring-up/token/occupancy/overflow/relink
// sequences followed by randomized traffic, all compared against a phase-level model.
module tb_bsg_link_downstream_ctrl;

  localparam int DEPTH = 64;
  localparam int TD    = 4;
  localparam int RC    = 8;

  localparam int PH_RST = 0;
  localparam int PH_DRN = 1;
  localparam int PH_ACT = 2;
  localparam int PH_ERR = 3;

  logic       clk = 1'b0;
  logic       rst, relink_i, io_valid_i, core_valid_i, core_ready_i;
  logic       core_valid_o, core_yumi_o, link_reset_o, token_o, link_up_o, overflow_o;
  logic [6:0] occupancy_o;

  always #5 clk = ~clk;

  bsg_link_downstream_ctrl #(
    .FIFO_DEPTH(DEPTH), .TOKEN_DECIMATION(TD), .RESET_CYCLES(RC)
  ) dut (
    .clk(clk), .rst(rst), .relink_i(relink_i), .io_valid_i(io_valid_i),
    .core_valid_i(core_valid_i), .core_ready_i(core_ready_i),
    .core_valid_o(core_valid_o), .core_yumi_o(core_yumi_o),
    .link_reset_o(link_reset_o), .token_o(token_o), .occupancy_o(occupancy_o),
    .link_up_o(link_up_o), .overflow_o(overflow_o)
  );

  int total = 0;
  int bad   = 0;

  // reference model: phase, reset cycles left, flit count, yumis since last token
  int m_ph, m_left, m_occ, m_pend;
  bit m_tok, m_ovf;

  // last observed values, for directed-sequence bookkeeping
  logic       l_lr, l_up, l_tok, l_yumi, l_cvo, l_ovf;
  logic [6:0] l_occ;
  int         n_tok = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, rl, iov, cv, cr);
    bit y;
    m_tok = 1'b0;
    if (r || rl) begin
      m_ph = PH_RST; m_left = RC; m_occ = 0; m_pend = 0; m_ovf = 1'b0;
    end else if (m_ph == PH_RST) begin
      m_left = m_left - 1;
      if (m_left == 0) m_ph = PH_DRN;
    end else if (m_ph == PH_DRN) begin
      if (!cv) m_ph = PH_ACT;
    end else if (m_ph == PH_ACT) begin
      y = cv && cr;
      if (iov && !y && m_occ == DEPTH) begin
        m_ovf = 1'b1; m_ph = PH_ERR;
      end else if (iov && !y) begin
        m_occ = m_occ + 1;
      end else if (y && !iov && m_occ > 0) begin
        m_occ = m_occ - 1;
      end
      if (y) begin
        m_pend = m_pend + 1;
        if (m_pend == TD) begin m_pend = 0; m_tok = 1'b1; end
      end
    end
  endtask

  // Called at a negedge: drive, check, advance model across the next posedge.
  task automatic cyc(input bit r, rl, iov, cv, cr);
    bit e_lr, e_cv, e_y;
    rst = r; relink_i = rl; io_valid_i = iov; core_valid_i = cv; core_ready_i = cr;
    #1;
    e_lr = r || (m_ph == PH_RST);
    e_cv = !r && (m_ph == PH_ACT) && cv;
    e_y  = !r && (((m_ph == PH_DRN) && cv) || ((m_ph == PH_ACT) && cv && cr));
    chk("link_reset", link_reset_o, e_lr);
    chk("core_valid", core_valid_o, e_cv);
    chk("core_yumi",  core_yumi_o,  e_y);
    chk("token",      token_o,      m_tok);
    chk("occupancy",  occupancy_o,  m_occ);
    chk("overflow",   overflow_o,   m_ovf);
    chk("link_up",    link_up_o,    m_ph == PH_ACT);
    l_lr = link_reset_o; l_up = link_up_o; l_tok = token_o; l_yumi = core_yumi_o;
    l_cvo = core_valid_o; l_occ = occupancy_o; l_ovf = overflow_o;
    if (token_o === 1'b1) n_tok++;
    model_step(r, rl, iov, cv, cr);
    @(negedge clk);
  endtask

  initial begin
    int cnt, cnt2, t0, mask;
    logic up9, up10;
    logic [6:0] occ_a, occ_b;
    int pio, pcv, pcr;

    rst = 1'b1; relink_i = 1'b0; io_valid_i = 1'b0; core_valid_i = 1'b0; core_ready_i = 1'b0;
    @(negedge clk); @(negedge clk);
    m_ph = PH_RST; m_left = RC; m_occ = 0; m_pend = 0; m_tok = 1'b0; m_ovf = 1'b0;

    // bring-up: 1 rst cycle + RC reset cycles, 1 drain cycle, then active
    cnt = 0; up9 = 1'b0; up10 = 1'b0;
    cyc(1, 0, 0, 0, 0); cnt += int'(l_lr);
    for (int i = 1; i <= 10; i++) begin
      cyc(0, 0, 0, 0, 0);
      cnt += int'(l_lr);
      if (i == 9)  up9  = l_up;
      if (i == 10) up10 = l_up;
    end
    chk("bringup_lr_cycles", cnt, 9);
    chk("bringup_drain_up",  up9, 0);
    chk("bringup_active_up", up10, 1);

    // tokens: 8 yumis -> pulses one cycle after the 4th and 8th
    mask = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) cyc(0, 0, 0, 1, 1); else cyc(0, 0, 0, 0, 0);
      if (l_tok === 1'b1) mask |= (1 << i);
    end
    chk("token_positions", mask, 'h110);

    // occupancy: 10 writes, 3 write+yumi, 10 yumis
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 1, 1);
      if (i == 0) occ_a = l_occ;
    end
    occ_b = occupancy_o;
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0);
    chk("occ_after_writes", occ_a, 10);
    chk("occ_after_both",   occ_b, 10);
    chk("occ_end",          l_occ, 0);

    // overflow: 64 writes, 65th overflows, error blocks dequeue
    for (int i = 0; i < 65; i++) cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 1);
    chk("ovf_occ_frozen", l_occ, 64);
    chk("ovf_sticky",     l_ovf, 1);
    chk("ovf_link_down",  l_up, 0);
    chk("ovf_no_yumi",    l_yumi, 0);

    // relink out of error, then drain 3 stale flits with consumer not ready
    cyc(0, 1, 0, 0, 0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1, 0, 0);
      cnt += int'(l_lr);
      if (i == 0) begin
        chk("relink_ovf_clr", l_ovf, 0);
        chk("relink_occ_clr", l_occ, 0);
      end
    end
    chk("relink_lr_cycles", cnt, 8);
    cnt = 0; cnt2 = 0; t0 = n_tok;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 0);
      cnt  += int'(l_yumi);
      cnt2 += int'(l_cvo);
    end
    chk("drain_yumis",  cnt, 3);
    chk("drain_valid",  cnt2, 0);
    cyc(0, 0, 0, 0, 0);
    chk("drain_still",  l_up, 0);
    cyc(0, 0, 0, 0, 0);
    chk("drain_to_active", l_up, 1);
    chk("drain_no_token",  n_tok - t0, 0);

    // mid-operation relink with 3 pending yumis
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 1);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("relink_active", l_up, 1);
    t0 = n_tok;
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0);
    chk("relink_pend_cleared", n_tok - t0, 0);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0);
    chk("relink_fresh_token", n_tok - t0, 1);

    // randomized traffic in biased segments
    for (int s = 0; s < 12; s++) begin
      if (s % 3 == 0) begin
        pio = 90; pcv = 10; pcr = 50;
      end else begin
        pio = $urandom_range(5, 95); pcv = $urandom_range(5, 95); pcr = $urandom_range(5, 95);
      end
      for (int i = 0; i < 200; i++)
        cyc($urandom_range(0, 999) < 2, $urandom_range(0, 999) < 4,
            $urandom_range(0, 99) < pio, $urandom_range(0, 99) < pcv,
            $urandom_range(0, 99) < pcr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
